// File: rtl/hopfield_datapath_if.sv
// Controller <-> Hopfield datapath bundle.
// The master drives commands and the pattern; the slave returns state and status.
interface hopfield_datapath_if #(
    parameter int NEURON_COUNT = 8,
    parameter int WEIGHT_WIDTH = 4
);
    localparam int AW = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1;

    logic                    modify_neuron;
    logic                    modify_neuron_using_input;
    logic                    modify_weights;
    logic [NEURON_COUNT-1:0] pattern_in;
    logic [AW-1:0]           weight_rd_row;
    logic [AW-1:0]           weight_rd_col;
    logic [WEIGHT_WIDTH-1:0] weight_rd_data;
    logic [NEURON_COUNT-1:0] state_out;
    logic                    same_input;
    logic                    converged;

    modport master (
        output modify_neuron,
        output modify_neuron_using_input,
        output modify_weights,
        output pattern_in,
        output weight_rd_row,
        output weight_rd_col,
        input  weight_rd_data,
        input  state_out,
        input  same_input,
        input  converged
    );

    modport slave (
        input  modify_neuron,
        input  modify_neuron_using_input,
        input  modify_weights,
        input  pattern_in,
        input  weight_rd_row,
        input  weight_rd_col,
        output weight_rd_data,
        output state_out,
        output same_input,
        output converged
    );
endinterface

// File: rtl/hopfield_datapath.sv
// Bipolar Hopfield network: synchronous recall, Hebbian learning with
// saturating symmetric weights and a zero diagonal.
module hopfield_datapath #(
    parameter int NEURON_COUNT = 8,
    parameter int WEIGHT_WIDTH = 4
) (
    input logic clk,
    input logic rst,
    hopfield_datapath_if.slave bus
);
    localparam int N     = NEURON_COUNT;
    localparam int W     = WEIGHT_WIDTH;
    localparam int AW    = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = W + $clog2(N) + 1;

    localparam logic signed [W-1:0] WMAX = W'((1 << (W-1)) - 1);
    localparam logic signed [W-1:0] WMIN = -WMAX;

    logic signed [W-1:0]     w [N][N];
    logic signed [ACC_W-1:0] h [N];
    logic [N-1:0]            state;
    logic [N-1:0]            next_state;
    logic [N-1:0]            prev_pattern;
    logic                    prev_armed;
    logic                    prev_valid;
    logic                    conv;

    function automatic logic signed [ACC_W-1:0] ext(
        input logic signed [W-1:0] v
    );
        return {{(ACC_W-W){v[W-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] learn(
        input logic signed [W-1:0] v,
        input logic                agree
    );
        if (agree)
            return (v == WMAX) ? v : v + W'(1);
        else
            return (v == WMIN) ? v : v - W'(1);
    endfunction

    always_comb begin
        next_state = state;
        for (int i = 0; i < N; i++) begin
            h[i] = '0;
            for (int j = 0; j < N; j++) begin
                if (j != i) begin
                    if (state[j])
                        h[i] = h[i] + ext(w[i][j]);
                    else
                        h[i] = h[i] - ext(w[i][j]);
                end
            end
            // zero field keeps the neuron as it is
            if (h[i] != '0)
                next_state[i] = ~h[i][ACC_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= '0;
            conv         <= 1'b0;
            prev_pattern <= '0;
            prev_armed   <= 1'b0;
            prev_valid   <= 1'b0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    w[i][j] <= '0;
        end else begin
            prev_pattern <= bus.pattern_in;
            prev_armed   <= 1'b1;
            // the first sample after reset is not trusted as history
            prev_valid   <= prev_armed;

            if (bus.modify_neuron) begin
                if (bus.modify_neuron_using_input) begin
                    state <= bus.pattern_in;
                    conv  <= 1'b0;
                end else begin
                    state <= next_state;
                    conv  <= (next_state == state);
                end
            end

            if (bus.modify_weights)
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        if (i != j)
                            w[i][j] <= learn(w[i][j],
                                             state[i] ~^ state[j]);
        end
    end

    always_comb begin
        bus.weight_rd_data = '0;
        if (int'(bus.weight_rd_row) < N &&
            int'(bus.weight_rd_col) < N)
            bus.weight_rd_data =
                w[bus.weight_rd_row][bus.weight_rd_col];
    end

    assign bus.state_out  = state;
    assign bus.converged  = conv;
    assign bus.same_input = prev_valid &&
                            (bus.pattern_in == prev_pattern);

    logic [AW-1:0] unused_aw;
    assign unused_aw = '0;
endmodule
